// File: rtl/rs_issue_select_pkg.sv
// rs_issue_select_pkg: shared defaults and types for the RS issue/select stage.
//   DEF_RS_ENTRIES  - default number of reservation-station entries (power of two)
//   DEF_NUM_FUS     - default number of functional units
//   DEF_FU_LATENCY  - default issue-to-wake latency in cycles (>= 1)
//   rs_idx_t        - RS entry index
//   fu_id_t         - functional-unit identifier
//   wake_t          - {valid, idx} record carried through the latency pipeline
package rs_issue_select_pkg;

    localparam int unsigned DEF_RS_ENTRIES = 8;
    localparam int unsigned DEF_NUM_FUS    = 2;
    localparam int unsigned DEF_FU_LATENCY = 2;

    localparam int unsigned DEF_IDX_W = $clog2(DEF_RS_ENTRIES);
    localparam int unsigned DEF_FU_W  = (DEF_NUM_FUS > 1) ? $clog2(DEF_NUM_FUS) : 1;

    typedef logic [DEF_IDX_W-1:0] rs_idx_t;
    typedef logic [DEF_FU_W-1:0]  fu_id_t;

    typedef struct packed {
        logic    valid;
        rs_idx_t idx;
    } wake_t;

endpackage

// File: rtl/rs_issue_select_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter with an internal rotating pointer.
//   clk, rst     - clock, asynchronous active-high reset (pointer -> 0)
//   req[N]       - request vector
//   en           - grant enable; with en low nothing is granted and the pointer holds
//   grant[N]     - one-hot grant (combinational)
//   grant_valid  - a grant is being issued this cycle
//   grant_idx    - index of the granted request
module rr_arbiter #(
    parameter  int unsigned N = 8,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] ptr;
    logic [W-1:0] idx;
    logic [W-1:0] sel;
    logic         found;

    // Scan upward from ptr; the W-bit add wraps modulo N since N is a power of two.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = ptr + W'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign grant_valid = found & en;
    assign grant_idx   = sel;
    assign grant       = grant_valid ? (N'(1) << sel) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= sel + W'(1);
        end
    end

endmodule

// File: rtl/rs_issue_select.sv
// rs_issue_select: issue stage downstream of the reservation station.
// Per-FU round-robin select over ready RS entries, registered issue toward each
// FU, and a fixed-latency pipeline that broadcasts a wake-up when the result is due.
//   clk, rst     - clock, asynchronous active-high reset
//   reqs         - per-entry valid-and-operands-ready
//   entry_fu     - target FU of each entry
//   fu_ready     - FU can accept an op this cycle
//   flush        - squash issue registers and in-flight wakes
//   grant        - combinational grant back to the RS (one per FU max)
//   issue_valid  - registered op-issued strobe per FU
//   issue_entry  - registered issued entry index per FU
//   wake_valid   - registered result-due strobe per FU
//   wake_entry   - registered entry index being woken per FU
module rs_issue_select
    import rs_issue_select_pkg::*;
#(
    parameter  int unsigned RS_ENTRIES = DEF_RS_ENTRIES,
    parameter  int unsigned NUM_FUS    = DEF_NUM_FUS,
    parameter  int unsigned FU_LATENCY = DEF_FU_LATENCY,
    localparam int unsigned IDX_W      = $clog2(RS_ENTRIES),
    localparam int unsigned FU_W       = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [RS_ENTRIES-1:0]               reqs,
    input  logic [RS_ENTRIES-1:0][FU_W-1:0]     entry_fu,
    input  logic [NUM_FUS-1:0]                  fu_ready,
    input  logic                                flush,
    output logic [RS_ENTRIES-1:0]               grant,
    output logic [NUM_FUS-1:0]                  issue_valid,
    output logic [NUM_FUS-1:0][IDX_W-1:0]       issue_entry,
    output logic [NUM_FUS-1:0]                  wake_valid,
    output logic [NUM_FUS-1:0][IDX_W-1:0]       wake_entry
);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } stage_t;

    logic [NUM_FUS-1:0][RS_ENTRIES-1:0] fu_grant;
    logic [NUM_FUS-1:0]                 fu_gnt_valid;
    logic [NUM_FUS-1:0][IDX_W-1:0]      fu_gnt_idx;

    stage_t pipe [NUM_FUS][FU_LATENCY];

    for (genvar f = 0; f < NUM_FUS; f++) begin : g_fu
        logic [RS_ENTRIES-1:0] req_f;
        logic [RS_ENTRIES-1:0] grant_f;
        logic                  gv_f;
        logic [IDX_W-1:0]      gi_f;

        // Entries tagged with an FU id >= NUM_FUS match no arbiter.
        always_comb begin
            req_f = '0;
            for (int unsigned e = 0; e < RS_ENTRIES; e++) begin
                req_f[e] = reqs[e] && (entry_fu[e] == FU_W'(f));
            end
        end

        rr_arbiter #(.N(RS_ENTRIES)) u_arb (
            .clk         (clk),
            .rst         (rst),
            .req         (req_f),
            .en          (fu_ready[f] & ~flush & ~rst),
            .grant       (grant_f),
            .grant_valid (gv_f),
            .grant_idx   (gi_f)
        );

        assign fu_grant[f]     = grant_f;
        assign fu_gnt_valid[f] = gv_f;
        assign fu_gnt_idx[f]   = gi_f;
    end

    // Candidate sets are disjoint per FU, so OR-merging cannot double-grant.
    always_comb begin
        grant = '0;
        for (int unsigned f = 0; f < NUM_FUS; f++) begin
            grant = grant | fu_grant[f];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid <= '0;
            issue_entry <= '0;
            for (int unsigned f = 0; f < NUM_FUS; f++) begin
                for (int unsigned s = 0; s < FU_LATENCY; s++) begin
                    pipe[f][s] <= '0;
                end
            end
        end else if (flush) begin
            issue_valid <= '0;
            issue_entry <= '0;
            for (int unsigned f = 0; f < NUM_FUS; f++) begin
                for (int unsigned s = 0; s < FU_LATENCY; s++) begin
                    pipe[f][s] <= '0;
                end
            end
        end else begin
            for (int unsigned f = 0; f < NUM_FUS; f++) begin
                issue_valid[f] <= fu_gnt_valid[f];
                if (fu_gnt_valid[f]) begin
                    issue_entry[f] <= fu_gnt_idx[f];
                end
                pipe[f][0] <= '{valid: issue_valid[f], idx: issue_entry[f]};
                for (int unsigned s = 1; s < FU_LATENCY; s++) begin
                    pipe[f][s] <= pipe[f][s-1];
                end
            end
        end
    end

    // Last pipeline stage is itself a register, so the wake outputs are registered.
    always_comb begin
        wake_valid = '0;
        wake_entry = '0;
        for (int unsigned f = 0; f < NUM_FUS; f++) begin
            wake_valid[f] = pipe[f][FU_LATENCY-1].valid;
            wake_entry[f] = pipe[f][FU_LATENCY-1].idx;
        end
    end

endmodule

// File: tb/tb_rs_issue_select.sv
module tb_rs_issue_select;

    localparam int unsigned RS  = 8;
    localparam int unsigned NF  = 2;
    localparam int unsigned LAT = 2;

    logic                clk;
    logic                rst;
    logic [RS-1:0]       reqs;
    logic [RS-1:0][0:0]  entry_fu;
    logic [NF-1:0]       fu_ready;
    logic                flush;
    logic [RS-1:0]       grant;
    logic [NF-1:0]       issue_valid;
    logic [NF-1:0][2:0]  issue_entry;
    logic [NF-1:0]       wake_valid;
    logic [NF-1:0][2:0]  wake_entry;

    rs_issue_select #(
        .RS_ENTRIES (RS),
        .NUM_FUS    (NF),
        .FU_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reqs        (reqs),
        .entry_fu    (entry_fu),
        .fu_ready    (fu_ready),
        .flush       (flush),
        .grant       (grant),
        .issue_valid (issue_valid),
        .issue_entry (issue_entry),
        .wake_valid  (wake_valid),
        .wake_entry  (wake_entry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit wake;
        int cyc;
        int fu;
        int ent;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cyc %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: match each DUT strobe against the expected event
    // for that FU, kind and cycle; flag unexpected and missing events.
    task automatic check_evt(input bit wk, input int f, input logic v, input logic [2:0] e);
        int hit;
        string kind;
        hit  = -1;
        kind = wk ? "wake" : "issue";
        for (int i = 0; i < exp_q.size(); i++) begin
            if (hit < 0 && exp_q[i].wake == wk && exp_q[i].fu == f && exp_q[i].cyc == cyc)
                hit = i;
        end
        if (v) begin
            total++;
            if (hit < 0) begin
                bad++;
                $display("FAIL %s fu%0d unexpected (cyc %0d): got entry %0d expected no event",
                         kind, f, cyc, e);
            end else begin
                if (int'(e) != exp_q[hit].ent) begin
                    bad++;
                    $display("FAIL %s fu%0d entry (cyc %0d): got %0d expected %0d",
                             kind, f, cyc, e, exp_q[hit].ent);
                end
                exp_q.delete(hit);
            end
        end else if (hit >= 0) begin
            total++;
            bad++;
            $display("FAIL %s fu%0d missing (cyc %0d): got no event expected entry %0d",
                     kind, f, cyc, exp_q[hit].ent);
            exp_q.delete(hit);
        end
    endtask

    always @(negedge clk) begin
        for (int f = 0; f < NF; f++) begin
            check_evt(1'b0, f, issue_valid[f], issue_entry[f]);
            check_evt(1'b1, f, wake_valid[f], wake_entry[f]);
        end
    end

    // One cycle of stimulus. fu_map bit e is the target FU of entry e.
    // Expected grant is checked combinationally; issue/wake expectations are queued.
    task automatic drive(input string name, input logic [7:0] r, input logic [7:0] fu_map,
                         input logic [1:0] rdy, input logic fl, input logic [7:0] eg);
        @(posedge clk);
        #2;
        reqs     = r;
        fu_ready = rdy;
        flush    = fl;
        for (int e = 0; e < RS; e++) entry_fu[e] = fu_map[e];
        #2;
        chk(name, 32'(grant), 32'(eg));
        if (fl) begin
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].wake && exp_q[i].cyc > cyc) exp_q.delete(i);
        end
        for (int e = 0; e < RS; e++) begin
            if (eg[e]) begin
                exp_q.push_back('{1'b0, cyc + 1, int'(fu_map[e]), e});
                exp_q.push_back('{1'b1, cyc + 1 + LAT, int'(fu_map[e]), e});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive("idle_grant", 8'h00, 8'h00, 2'b11, 1'b0, 8'h00);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_issue_valid"}, 32'(issue_valid), 32'h0);
        chk({tag, "_issue_entry"}, 32'(issue_entry), 32'h0);
        chk({tag, "_wake_valid"}, 32'(wake_valid), 32'h0);
        chk({tag, "_wake_entry"}, 32'(wake_entry), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        reqs     = 8'hFF;
        fu_ready = 2'b11;
        flush    = 1'b0;
        entry_fu = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #2;
        rst  = 1'b0;
        reqs = 8'h00;

        // Round-robin over entries 1,5,6 on FU0 starting from pointer 0.
        drive("rr_1st", 8'b0110_0010, 8'h00, 2'b11, 1'b0, 8'b0000_0010);
        drive("rr_2nd", 8'b0110_0010, 8'h00, 2'b11, 1'b0, 8'b0010_0000);
        drive("rr_3rd", 8'b0110_0010, 8'h00, 2'b11, 1'b0, 8'b0100_0000);
        drive("rr_4th", 8'b0110_0010, 8'h00, 2'b11, 1'b0, 8'b0000_0010);
        idle(1);

        // Single op, entry 2 -> FU0.
        drive("single", 8'b0000_0100, 8'h00, 2'b11, 1'b0, 8'b0000_0100);
        idle(4);

        // Dual FU in parallel: entry 0 -> FU0, entry 3 -> FU1.
        drive("dual", 8'b0000_1001, 8'b0000_1000, 2'b11, 1'b0, 8'b0000_1001);
        idle(3);

        // Backpressure on FU0; FU1 (entry 6) proceeds.
        drive("bp_fu1_ok", 8'b0101_0000, 8'b0100_0000, 2'b10, 1'b0, 8'b0100_0000);
        drive("bp_hold", 8'b0001_0000, 8'h00, 2'b10, 1'b0, 8'h00);
        drive("bp_release", 8'b0001_0000, 8'h00, 2'b11, 1'b0, 8'b0001_0000);
        idle(3);

        // Pointer wrap: FU0 pointer 5 selects 7, then wraps to 0.
        drive("wrap_7", 8'b1000_0001, 8'h00, 2'b11, 1'b0, 8'b1000_0000);
        drive("wrap_0", 8'b1000_0001, 8'h00, 2'b11, 1'b0, 8'b0000_0001);
        idle(3);

        // Flush mid-flight: entry 7 issued, then flushed before its wake.
        drive("fl_issue", 8'b1000_0000, 8'h00, 2'b11, 1'b0, 8'b1000_0000);
        drive("fl_grant_off", 8'b1000_0000, 8'h00, 2'b11, 1'b1, 8'h00);
        idle(4);

        // FU1 pointer (at 7) survives the flush: picks 7 over 0.
        drive("fl_ptr_kept", 8'b1000_0001, 8'b1000_0001, 2'b11, 1'b0, 8'b1000_0000);
        idle(3);

        // Async reset mid-flight: entries 6 (FU0) and 5 (FU1) issued, wakes pending.
        drive("rst_issue", 8'b0110_0000, 8'b0010_0000, 2'b11, 1'b0, 8'b0110_0000);
        idle(1);
        @(posedge clk);
        #2;
        rst      = 1'b1;
        reqs     = 8'hFF;
        fu_ready = 2'b11;
        #1;
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].cyc >= cyc) exp_q.delete(i);
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #2;
        rst  = 1'b0;
        reqs = 8'h00;
        idle(5);

        // Pointers cleared by reset: FU0 picks entry 0 over 7.
        drive("post_rst_ptr", 8'b1000_0001, 8'h00, 2'b11, 1'b0, 8'b0000_0001);
        idle(4);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs_issue_select.md
Name: rs_issue_select

Overview:
- Issue stage directly downstream of the reservation station (RS).
- Consumes the RS per-entry request vector and target-FU tags. Performs round-robin select per functional unit and returns a one-hot grant so the RS frees the entry.
- Registers the issued entry index toward each FU.
- Tracks in-flight ops through a per-FU latency pipeline. Broadcasts a wake-up (entry index) when the result is due, so the RS can clear the matching dependency_mask column.

Parameters:
- RS_ENTRIES, 8: number of RS entries; power of two, ≥2.
- NUM_FUS, 2: number of functional units.
- FU_LATENCY, 2: cycles from issue_valid to wake_valid; must be ≥1. FUs are fully pipelined.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- reqs  in  RS_ENTRIES  bit e = entry e valid and operands ready.
- entry_fu  in  RS_ENTRIES x FU_W  target FU of each entry; FU_W = $clog2(NUM_FUS).
- fu_ready  in  NUM_FUS  FU f can accept an op this cycle.
- flush  in  1  squash all in-flight state (mispredict recovery).
- grant  out  RS_ENTRIES  combinational one-hot-per-FU grant back to RS; RS deallocates granted entries at this edge.
- issue_valid  out  NUM_FUS  registered; op issued to FU f.
- issue_entry  out  NUM_FUS x IDX_W  registered entry index per FU; IDX_W = $clog2(RS_ENTRIES).
- wake_valid  out  NUM_FUS  registered; result of FU f is due.
- wake_entry  out  NUM_FUS x IDX_W  registered entry index being woken.

Behaviour:
- Reset (async assert): issue_valid=0, issue_entry=0, wake_valid=0, wake_entry=0, all RR pointers=0, all latency stages empty. grant is forced 0 while rst is high.
- Candidates for FU f = entries e with reqs[e]=1 and entry_fu[e]==f. entry_fu values ≥ NUM_FUS are never granted.
- Select for FU f: the first candidate found scanning upward from rr_ptr[f], wrapping modulo RS_ENTRIES. grant[e]=1 only if fu_ready[f]=1 and flush=0.
- At most one grant per FU per cycle. An entry is granted at most once, since it targets a single FU.
- On a grant to entry e for FU f at edge N:
  - rr_ptr[f] ← (e+1) mod RS_ENTRIES.
  - In cycle N+1: issue_valid[f]=1 and issue_entry[f]=e, for exactly one cycle.
- No grant: rr_ptr[f] holds and issue_valid[f]=0 next cycle.
- Wake-up:
  - Each FU has a FU_LATENCY-deep shift pipeline of {valid, idx}, loaded from issue_valid/issue_entry.
  - wake_valid[f] asserts FU_LATENCY cycles after the corresponding issue_valid[f] cycle.
  - Back-to-back issues produce back-to-back wakes; no stalls.
- Flush (synchronous effect at the edge where flush=1): clears the issue registers and all latency stages, and suppresses grant in the same cycle. RR pointers are preserved. Outputs are 0 on the following cycle.
- Simultaneous flush and fu_ready: flush wins; no grant.
- Reset mid-operation: all in-flight wakes are lost. No spurious wake after reset release.
- Wrap: rr_ptr=RS_ENTRIES-1 with a grant to that entry returns the pointer to 0.
- fu_ready low for FU f: requests for f remain pending with no side effects. Other FUs are unaffected.

Decomposition:
- CORE_PKG gains:
  - RS_ENTRIES, NUM_FUS, FU_LATENCY defaults.
  - rs_idx_t (logic [IDX_W-1:0]) and fu_id_t (logic [FU_W-1:0]).
  - typedef struct packed {logic valid; rs_idx_t idx;} wake_t.
- One sub-module: rr_arbiter, parameterised N, with req/en/grant one-hot and an internal pointer. Instantiated NUM_FUS times.
- The latency pipeline is inline.

Test Plan:
- Single op: reqs=8'b0000_0100, entry_fu[2]=0, fu_ready=2'b11 → grant=8'b0000_0100 same cycle; next cycle issue_valid=2'b01 and issue_entry[0]=2; two cycles later wake_valid[0]=1 and wake_entry[0]=2.
- Round-robin fairness: entries 1, 5, 6 all target FU0 and stay requesting (re-asserted each cycle) → grant order 1, 5, 6, 1; rr_ptr wraps from 7 to 0.
- Dual FU parallel: entry 0 → FU0 and entry 3 → FU1 in the same cycle → grant=8'b0000_1001; issue_valid=2'b11 next cycle; wake_valid=2'b11 after FU_LATENCY cycles.
- Backpressure: fu_ready=2'b10 with entry 4 → FU0 → grant=0 and no issue; raise fu_ready[0] → entry 4 granted that cycle.
- Flush mid-flight: issue entry 7 to FU0, assert flush the next cycle → no wake_valid ever appears for entry 7; grant=0 during flush.
- Async reset mid-flight: assert rst between clock edges while wakes are pending → all outputs 0 immediately; none reappear after release.
